// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the dmem port A arbiter and its read-tag pipeline.
package dmem_arb_pkg;

  localparam int DMEM_AW = 11;
  localparam int DMEM_DW = 16;
  localparam int CPU_AW  = 16;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_VGA = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
    logic   err;
  } rd_tag_t;

endpackage

// File: rtl/dmem_rd_tag_pipe.sv
// Delays each read's ownership tag by the RAM read latency so it meets mem_q at the tail.
module dmem_rd_tag_pipe
  import dmem_arb_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t pipe_q [RD_LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tag_o = pipe_q[RD_LATENCY-1];

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares dmem port A between CPU and VGA reader: combinational grant with a VGA
// starvation guard, and a tagged, registered read-return path for both owners.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW         = DMEM_AW,
  parameter int DW         = DMEM_DW,
  parameter int RD_LATENCY = 1,
  parameter int MAX_WAIT   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_ren,
  input  logic                cpu_wren,
  input  logic [CPU_AW-1:0]   cpu_addr,
  input  logic [DW-1:0]       cpu_wdata,
  output logic                cpu_stall,
  output logic [DW-1:0]       cpu_rdata,
  output logic                cpu_rvalid,
  output logic                cpu_addr_err,
  input  logic                vga_req,
  input  logic [AW-1:0]       vga_addr,
  output logic                vga_gnt,
  output logic [DW-1:0]       vga_rdata,
  output logic                vga_rvalid,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  output logic                mem_ren,
  output logic                mem_wren,
  input  logic [DW-1:0]       mem_q
);

  localparam int WCW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  logic           cpu_req;
  logic           cpu_oor;
  logic           force_vga;
  logic           cpu_gnt;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  rd_tag_t        tag_push, tag_tail;
  logic           cpu_rvalid_q, cpu_rvalid_d;
  logic           vga_rvalid_q, vga_rvalid_d;
  logic           cpu_rd_err_q, cpu_rd_err_d;
  logic [DW-1:0]  cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]  vga_rdata_q, vga_rdata_d;

  // Grant and RAM drive; an out-of-range CPU access takes the slot without touching the RAM.
  always_comb begin
    cpu_req   = cpu_ren | cpu_wren;
    cpu_oor   = |cpu_addr[CPU_AW-1:AW];
    force_vga = vga_req && (wait_cnt_q == WCW'(MAX_WAIT));
    vga_gnt   = vga_req && (force_vga || !cpu_req);
    cpu_gnt   = cpu_req && !force_vga;
    cpu_stall = cpu_req && force_vga;

    mem_addr  = vga_gnt ? vga_addr : cpu_addr[AW-1:0];
    mem_wdata = cpu_wdata;
    mem_wren  = cpu_gnt && cpu_wren && !cpu_oor;
    mem_ren   = vga_gnt || (cpu_gnt && !cpu_wren && !cpu_oor);

    tag_push.valid = vga_gnt || (cpu_gnt && !cpu_wren);
    tag_push.owner = vga_gnt ? OWNER_VGA : OWNER_CPU;
    tag_push.err   = !vga_gnt && cpu_oor;
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!vga_req || vga_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WCW'(MAX_WAIT)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  dmem_rd_tag_pipe #(
    .RD_LATENCY (RD_LATENCY)
  ) u_tag_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .tag_i (tag_push),
    .tag_o (tag_tail)
  );

  // Tail of the tag pipeline lines up with mem_q; capture into the owner's return register.
  always_comb begin
    cpu_rvalid_d = tag_tail.valid && (tag_tail.owner == OWNER_CPU);
    vga_rvalid_d = tag_tail.valid && (tag_tail.owner == OWNER_VGA);
    cpu_rd_err_d = cpu_rvalid_d && tag_tail.err;
    cpu_rdata_d  = cpu_rdata_q;
    vga_rdata_d  = vga_rdata_q;
    if (cpu_rvalid_d) begin
      cpu_rdata_d = tag_tail.err ? '0 : mem_q;
    end
    if (vga_rvalid_d) begin
      vga_rdata_d = mem_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q   <= '0;
      cpu_rvalid_q <= 1'b0;
      vga_rvalid_q <= 1'b0;
      cpu_rd_err_q <= 1'b0;
      cpu_rdata_q  <= '0;
      vga_rdata_q  <= '0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      vga_rvalid_q <= vga_rvalid_d;
      cpu_rd_err_q <= cpu_rd_err_d;
      cpu_rdata_q  <= cpu_rdata_d;
      vga_rdata_q  <= vga_rdata_d;
    end
  end

  // Write errors are reported in the grant cycle, read errors with their return.
  assign cpu_addr_err = cpu_rd_err_q | (cpu_gnt && cpu_wren && cpu_oor);
  assign cpu_rvalid   = cpu_rvalid_q;
  assign vga_rvalid   = vga_rvalid_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign vga_rdata    = vga_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench: two arbiters (RD_LATENCY 1 and 2) share one stimulus stream, each with its own RAM.
module tb_dmem_port_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW       = 11;
  localparam int DW       = 16;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          cpu_ren = 1'b0, cpu_wren = 1'b0;
  logic [15:0]   cpu_addr = '0, cpu_wdata = '0;
  logic          vga_req = 1'b0;
  logic [AW-1:0] vga_addr = '0;

  logic          cpu_stall_w [2];
  logic [DW-1:0] cpu_rdata_w [2];
  logic          cpu_rvalid_w [2];
  logic          cpu_addr_err_w [2];
  logic          vga_gnt_w [2];
  logic [DW-1:0] vga_rdata_w [2];
  logic          vga_rvalid_w [2];
  logic [AW-1:0] mem_addr_w [2];
  logic [DW-1:0] mem_wdata_w [2];
  logic          mem_ren_w [2];
  logic          mem_wren_w [2];
  logic [DW-1:0] mem_q_w [2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_val(int i);
    return (i == 5) ? 16'hBEEF : 16'(i * 40503 + 7);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [15:0] ram [2048];
    logic [15:0] q_a = '0, q_b = '0;
    bit loaded = 1'b0;

    dmem_port_arbiter #(.AW(AW), .DW(DW), .RD_LATENCY(g + 1), .MAX_WAIT(MAX_WAIT)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_ren(cpu_ren), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_stall(cpu_stall_w[g]), .cpu_rdata(cpu_rdata_w[g]), .cpu_rvalid(cpu_rvalid_w[g]),
      .cpu_addr_err(cpu_addr_err_w[g]),
      .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt_w[g]),
      .vga_rdata(vga_rdata_w[g]), .vga_rvalid(vga_rvalid_w[g]),
      .mem_addr(mem_addr_w[g]), .mem_wdata(mem_wdata_w[g]), .mem_ren(mem_ren_w[g]),
      .mem_wren(mem_wren_w[g]), .mem_q(mem_q_w[g])
    );

    // Behavioural RAM: registered read, write visible to the next cycle's read.
    always @(posedge clk) begin
      if (!loaded) begin
        for (int i = 0; i < 2048; i++) ram[i] = init_val(i);
        loaded = 1'b1;
      end
      if (mem_ren_w[g]) q_a <= ram[mem_addr_w[g]];
      q_b <= q_a;
      if (mem_wren_w[g]) ram[mem_addr_w[g]] = mem_wdata_w[g];
    end
    assign mem_q_w[g] = (g == 0) ? q_a : q_b;
  end

  typedef struct {
    bit          vga;
    logic [15:0] data;
    bit          err;
    int          due;
  } ret_t;

  ret_t          sbq0[$];
  ret_t          sbq1[$];
  logic [15:0]   ref_mem [2048];
  int            ref_wait = 0;
  bit            e_vgnt = 0, e_stall = 0, e_ren = 0, e_wren = 0, e_wr_err = 0;
  logic [AW-1:0] e_addr = '0;
  int            nchk = 0, nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One bus cycle: drive, predict from the arbitration rules, check grant outputs, queue returns.
  task automatic step(input logic ren, input logic wren, input logic [15:0] addr,
                      input logic [15:0] wdata, input logic vreq, input logic [AW-1:0] vaddr);
    bit creq, frc, oor, rd_ret;
    ret_t r;
    cpu_ren = ren; cpu_wren = wren; cpu_addr = addr; cpu_wdata = wdata;
    vga_req = vreq; vga_addr = vaddr;
    creq     = ren | wren;
    oor      = (addr[15:AW] != 0);
    frc      = vreq && (ref_wait == MAX_WAIT);
    e_vgnt   = vreq && (frc || !creq);
    e_stall  = creq && frc;
    e_wren   = creq && !frc && wren && !oor;
    e_ren    = e_vgnt || (creq && !frc && !wren && !oor);
    e_addr   = e_vgnt ? vaddr : addr[AW-1:0];
    e_wr_err = creq && !frc && wren && oor;
    rd_ret   = e_vgnt || (creq && !frc && !wren);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("vga_gnt[%0d]", g), 32'(vga_gnt_w[g]), 32'(e_vgnt));
      chk($sformatf("cpu_stall[%0d]", g), 32'(cpu_stall_w[g]), 32'(e_stall));
      chk($sformatf("mem_ren[%0d]", g), 32'(mem_ren_w[g]), 32'(e_ren));
      chk($sformatf("mem_wren[%0d]", g), 32'(mem_wren_w[g]), 32'(e_wren));
      if (e_ren || e_wren) chk($sformatf("mem_addr[%0d]", g), 32'(mem_addr_w[g]), 32'(e_addr));
      if (e_wren) chk($sformatf("mem_wdata[%0d]", g), 32'(mem_wdata_w[g]), 32'(wdata));
    end
    if (rd_ret) begin
      r.vga  = e_vgnt;
      r.err  = !e_vgnt && oor;
      r.data = r.err ? 16'h0000 : ref_mem[e_addr];
      r.due  = cyc + 2;
      sbq0.push_back(r);
      r.due  = cyc + 3;
      sbq1.push_back(r);
    end
    if (e_wren) ref_mem[addr[AW-1:0]] = wdata;
    ref_wait = (vreq && !e_vgnt) ? ((ref_wait < MAX_WAIT) ? ref_wait + 1 : MAX_WAIT) : 0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, '0);
  endtask

  task automatic do_reset(input int hold);
    cpu_ren = 0; cpu_wren = 0; vga_req = 0;
    rst_n = 1'b0;
    sbq0.delete(); sbq1.delete();
    ref_wait = 0; e_wr_err = 0;
    repeat (hold) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        chk($sformatf("rst_cpu_rvalid[%0d]", g), 32'(cpu_rvalid_w[g]), 32'd0);
        chk($sformatf("rst_vga_rvalid[%0d]", g), 32'(vga_rvalid_w[g]), 32'd0);
        chk($sformatf("rst_cpu_addr_err[%0d]", g), 32'(cpu_addr_err_w[g]), 32'd0);
        chk($sformatf("rst_cpu_rdata[%0d]", g), 32'(cpu_rdata_w[g]), 32'd0);
        chk($sformatf("rst_vga_rdata[%0d]", g), 32'(vga_rdata_w[g]), 32'd0);
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every rvalid must match the oldest queued return in owner, data, error and cycle.
  task automatic mon(input int g);
    bit have;
    ret_t e;
    bit rc, rv;
    have = (g == 0) ? (sbq0.size() > 0) : (sbq1.size() > 0);
    if (have) e = (g == 0) ? sbq0[0] : sbq1[0];
    rc = cpu_rvalid_w[g];
    rv = vga_rvalid_w[g];
    if (rc || rv) begin
      if (!have) begin
        chk($sformatf("rvalid_unexpected[%0d]", g), 32'({rc, rv}), 32'd0);
      end else begin
        if (g == 0) void'(sbq0.pop_front()); else void'(sbq1.pop_front());
        chk($sformatf("rvalid_both[%0d]", g), 32'(rc & rv), 32'd0);
        chk($sformatf("ret_owner_vga[%0d]", g), 32'(rv), 32'(e.vga));
        chk($sformatf("ret_cycle[%0d]", g), 32'(cyc), 32'(e.due));
        if (e.vga) begin
          chk($sformatf("vga_rdata[%0d]", g), 32'(vga_rdata_w[g]), 32'(e.data));
        end else begin
          chk($sformatf("cpu_rdata[%0d]", g), 32'(cpu_rdata_w[g]), 32'(e.data));
          chk($sformatf("cpu_addr_err_ret[%0d]", g), 32'(cpu_addr_err_w[g]), 32'(e.err | e_wr_err));
        end
      end
    end else begin
      chk($sformatf("cpu_addr_err[%0d]", g), 32'(cpu_addr_err_w[g]), 32'(e_wr_err));
      if (have && e.due < cyc) begin
        chk($sformatf("ret_missing[%0d]", g), 32'(e.due), 32'(cyc));
        if (g == 0) void'(sbq0.pop_front()); else void'(sbq1.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0);
      mon(1);
    end
  end

  initial begin
    bit            cp, vp;
    logic          cr, cw;
    logic [15:0]   ca, cd;
    logic [AW-1:0] va;
    for (int i = 0; i < 2048; i++) ref_mem[i] = init_val(i);
    #1;
    do_reset(2);

    // CPU read of a preloaded word
    step(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, '0);
    idle(4);

    // VGA held against a continuous CPU read stream: forced on the 5th request cycle
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'(16'h0020 + i), 16'h0000, 1'b1, 11'h100);
    chk("vga_forced_gnt", 32'(e_vgnt), 32'd1);
    chk("vga_forced_stall", 32'(e_stall), 32'd1);
    chk("wait_cnt_clear0", 32'(g_dut[0].u_dut.wait_cnt_q), 32'd0);
    chk("wait_cnt_clear1", 32'(g_dut[1].u_dut.wait_cnt_q), 32'd0);
    idle(4);

    // CPU write then VGA read of the same word
    step(1'b0, 1'b1, 16'h0010, 16'h1234, 1'b0, '0);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 11'h010);
    chk("raw_model", 32'(ref_mem[16]), 32'h1234);
    idle(4);

    // Out-of-range read and write; also a read+write pair resolving as a write
    step(1'b1, 1'b0, 16'h0900, 16'h0000, 1'b0, '0);
    step(1'b0, 1'b1, 16'hFFFF, 16'hAAAA, 1'b0, '0);
    step(1'b1, 1'b1, 16'h0033, 16'h5A5A, 1'b0, '0);
    idle(4);

    // Alternating CPU / VGA reads every cycle
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) step(1'b1, 1'b0, 16'($urandom_range(0, 2047)), 16'h0000, 1'b0, '0);
      else            step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, AW'($urandom_range(0, 2047)));
    end
    idle(4);

    // Reset with two reads in flight: those returns must never appear
    step(1'b1, 1'b0, 16'h0007, 16'h0000, 1'b0, '0);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 11'h008);
    do_reset(2);
    idle(6);

    // Randomized traffic with request-hold rules on both sides
    cp = 0; vp = 0; cr = 0; cw = 0; ca = '0; cd = '0; va = '0;
    for (int n = 0; n < 600; n++) begin
      if (!cp && ($urandom_range(0, 3) != 0)) begin
        cp = 1;
        cr = 1'($urandom_range(0, 1));
        cw = 1'($urandom_range(0, 1));
        if (!cr && !cw) cr = 1'b1;
        ca = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 2047));
        cd = 16'($urandom);
      end
      if (!vp && ($urandom_range(0, 2) == 0)) begin
        vp = 1;
        va = AW'($urandom_range(0, 2047));
      end
      step(cp ? cr : 1'b0, cp ? cw : 1'b0, ca, cd, vp, va);
      if (cp && !e_stall) cp = 0;
      if (vp && e_vgnt) vp = 0;
    end
    idle(6);
    chk("scoreboard_drained", 32'(sbq0.size() + sbq1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
